// File: rtl/id_pool_mp.sv
// id_pool_mp: lowest-free-first ID allocator with multi-port reclaim, flush and bad-free reporting.
module id_pool_mp #(
    parameter int NUM_IDS  = 8,
    parameter int NUM_FREE = 2,
    localparam int ID_W    = $clog2(NUM_IDS),
    localparam int CNT_W   = $clog2(NUM_IDS + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_flush,
    input  logic [NUM_FREE-1:0]      io_free_valid,
    input  logic [NUM_FREE*ID_W-1:0] io_free_bits,
    input  logic                     io_alloc_ready,
    output logic                     io_alloc_valid,
    output logic [ID_W-1:0]          io_alloc_bits,
    output logic [CNT_W-1:0]         io_free_count,
    output logic                     io_err_valid,
    output logic [ID_W-1:0]          io_err_id
);
    logic [NUM_IDS-1:0]  bitmap, bitmap_next, free_mask, take_mask;
    logic [ID_W-1:0]     select, sel_next, err_pick, err_id;
    logic                valid, err_valid, fire;
    logic [CNT_W-1:0]    count, cnt_next;
    logic [NUM_FREE-1:0] illegal;
    logic [ID_W-1:0]     fid [NUM_FREE];

    assign fire      = io_alloc_ready & valid;
    assign take_mask = fire ? NUM_IDS'(1) << select : '0;

    always_comb begin
        for (int p = 0; p < NUM_FREE; p++) fid[p] = io_free_bits[p*ID_W +: ID_W];
    end

    // Walk ports high to low so the lowest offending port ends up in err_pick.
    always_comb begin
        free_mask = '0;
        illegal   = '0;
        err_pick  = '0;
        for (int p = NUM_FREE - 1; p >= 0; p--) begin
            illegal[p] = int'(fid[p]) >= NUM_IDS || (bitmap[fid[p]] && !(fire && select == fid[p]));
            for (int q = 0; q < p; q++) illegal[p] = illegal[p] | (io_free_valid[q] && fid[q] == fid[p]);
            illegal[p] = illegal[p] & io_free_valid[p];
            if (illegal[p]) err_pick = fid[p];
            else if (io_free_valid[p]) free_mask[fid[p]] = 1'b1;
        end
    end

    assign bitmap_next = io_flush ? '1 : (bitmap & ~take_mask) | free_mask;

    always_comb begin
        sel_next = '0;
        cnt_next = '0;
        for (int i = NUM_IDS - 1; i >= 0; i--) begin
            if (bitmap_next[i]) sel_next = ID_W'(i);
            cnt_next = cnt_next + CNT_W'(bitmap_next[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bitmap    <= '1;
            select    <= '0;
            valid     <= 1'b1;
            count     <= CNT_W'(NUM_IDS);
            err_valid <= 1'b0;
            err_id    <= '0;
        end else begin
            bitmap    <= bitmap_next;
            count     <= cnt_next;
            err_valid <= !io_flush && |illegal;
            if (!io_flush && |illegal) err_id <= err_pick;
            // The offer only moves once taken (or when nothing was offered); an empty pool keeps the old select.
            if (io_flush || fire || !valid) begin
                valid <= |bitmap_next;
                if (|bitmap_next) select <= sel_next;
            end
        end
    end

    assign io_alloc_valid = valid;
    assign io_alloc_bits  = select;
    assign io_free_count  = count;
    assign io_err_valid   = err_valid;
    assign io_err_id      = err_id;
endmodule
